// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the decode/DSP sequencing controller.
package dsp_ctrl_pkg;

  localparam int DSP_TIMEOUT_DEF = 64;
  localparam int DSP_OP_W        = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } dsp_state_t;

  localparam logic [DSP_OP_W-1:0] DSP_OP_MUL  = 2'd0;
  localparam logic [DSP_OP_W-1:0] DSP_OP_MAC  = 2'd1;
  localparam logic [DSP_OP_W-1:0] DSP_OP_DIV  = 2'd2;
  localparam logic [DSP_OP_W-1:0] DSP_OP_SQRT = 2'd3;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_ex_WriteReg,
  input  logic       i_ex_MemRead,
  output logic       o_load_use
);

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign o_load_use = i_ex_MemRead & (i_ex_WriteReg != 5'd0) &
                      ((i_ex_WriteReg == i_id_rs1) | (i_ex_WriteReg == i_id_rs2));

endmodule

// File: rtl/dsp_hazard_ctrl.sv
// Decode-stage sequencing: load-use stall, multi-cycle DSP launch/hold/release,
// and branch-taken flush of IF/ID.
module dsp_hazard_ctrl
  import dsp_ctrl_pkg::*;
#(
  parameter int DSP_TIMEOUT = DSP_TIMEOUT_DEF,
  parameter int CNT_W       = 7,
  parameter int OP_W        = DSP_OP_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_id_start_dsp,
  input  logic [OP_W-1:0] i_id_op_dsp,
  input  logic            i_ex_MemRead,
  input  logic [4:0]      i_ex_WriteReg,
  input  logic            i_branch_taken,
  input  logic            i_dsp_done,
  output logic            o_stall,
  output logic            o_bubble,
  output logic            o_flush,
  output logic            o_dsp_start,
  output logic [OP_W-1:0] o_dsp_op,
  output logic            o_dsp_busy,
  output logic            o_dsp_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DSP_TIMEOUT - 1);

  dsp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_op;
  logic             r_timeout;

  logic w_load_use;
  logic w_stall;
  logic w_bubble;
  logic w_flush;
  logic w_start;
  logic w_busy;

  load_use_detect u_load_use_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_ex_WriteReg (i_ex_WriteReg),
    .i_ex_MemRead  (i_ex_MemRead),
    .o_load_use    (w_load_use)
  );

  // Sequencing FSM, wait counter, latched opcode and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_branch_taken) begin
            r_state <= IDLE;
          end else if (w_load_use) begin
            r_state <= IDLE;
          end else if (i_id_start_dsp) begin
            r_op    <= i_id_op_dsp;
            r_state <= LAUNCH;
          end else begin
            r_state <= IDLE;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= i_dsp_done ? RELEASE : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A done arriving on the last allowed cycle beats the timeout.
          if (i_dsp_done) begin
            r_state <= RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= RELEASE;
          end else begin
            r_state <= WAIT;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pipeline control decode from the current state and ID/EX inputs.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_start  = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_load_use || i_id_start_dsp) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else begin
          w_stall  = 1'b0;
        end
      end
      LAUNCH: begin
        w_start  = 1'b1;
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_busy   = 1'b1;
      end
      WAIT: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_busy   = 1'b1;
      end
      RELEASE: begin
        if (i_branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else begin
          w_flush  = 1'b0;
        end
      end
      default: begin
        w_stall  = 1'b0;
      end
    endcase
  end

  // Combinational controls are forced low while reset is held.
  assign o_stall       = w_stall  & i_reset;
  assign o_bubble      = w_bubble & i_reset;
  assign o_flush       = w_flush  & i_reset;
  assign o_dsp_start   = w_start  & i_reset;
  assign o_dsp_busy    = w_busy   & i_reset;
  assign o_dsp_op      = r_op;
  assign o_dsp_timeout = r_timeout;

endmodule

// File: tb/tb_dsp_hazard_ctrl.sv
// Scoreboard bench: the driver pushes the reference model's expected controls,
// an independent monitor pops and compares them mid-cycle.
module tb_dsp_hazard_ctrl;
  import dsp_ctrl_pkg::*;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, wr;
  logic       start, memrd, br, done;
  logic [1:0] op;
  logic       stall, bubble, flush, dstart, busy, tmo;
  logic [1:0] dop;

  dsp_hazard_ctrl #(.DSP_TIMEOUT(T), .CNT_W(7), .OP_W(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_start_dsp(start), .i_id_op_dsp(op), .i_ex_MemRead(memrd),
    .i_ex_WriteReg(wr), .i_branch_taken(br), .i_dsp_done(done),
    .o_stall(stall), .o_bubble(bubble), .o_flush(flush), .o_dsp_start(dstart),
    .o_dsp_op(dop), .o_dsp_busy(busy), .o_dsp_timeout(tmo)
  );

  always #5 clk = ~clk;

  // {stall, bubble, flush, start, busy, timeout, op[1:0]}
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  // Reference model: is an op in flight, cycles since its launch pulse,
  // whether the previous cycle ended an op, latched opcode, sticky flag.
  bit         m_in_op  = 1'b0;
  int         m_waited = 0;
  bit         m_rel    = 1'b0;
  bit         m_tmo    = 1'b0;
  logic [1:0] m_op     = 2'd0;

  task automatic cyc(input bit rst, input logic [4:0] a, input logic [4:0] b,
                     input bit s, input logic [1:0] o, input bit mr,
                     input logic [4:0] w, input bit bt, input bit dn);
    bit lu, es, eb, ef, est, ebz;
    @(negedge clk);
    reset = rst; rs1 = a; rs2 = b; start = s; op = o;
    memrd = mr; wr = w; br = bt; done = dn;
    lu = mr && (w != 5'd0) && (w == a || w == b);
    es = 1'b0; eb = 1'b0; ef = 1'b0; est = 1'b0; ebz = 1'b0;
    if (!rst) begin
      m_in_op = 1'b0; m_rel = 1'b0; m_tmo = 1'b0; m_op = 2'd0; m_waited = 0;
      exp_q.push_back(8'd0);
    end else begin
      logic [7:0] e;
      e = {6'd0, m_op};
      e[2] = m_tmo;
      if (m_in_op) begin
        es = 1'b1; eb = 1'b1; ebz = 1'b1; est = (m_waited == 0);
        if (dn) begin
          m_in_op = 1'b0; m_rel = 1'b1;
        end else if (m_waited == T) begin
          m_tmo = 1'b1; m_in_op = 1'b0; m_rel = 1'b1;
        end else begin
          m_waited++;
        end
      end else if (m_rel) begin
        ef = bt; eb = bt; m_rel = 1'b0;
      end else if (bt) begin
        ef = 1'b1; eb = 1'b1;
      end else if (lu) begin
        es = 1'b1; eb = 1'b1;
      end else if (s) begin
        es = 1'b1; eb = 1'b1; m_op = o; m_in_op = 1'b1; m_waited = 0;
      end
      e[7:3] = {es, eb, ef, est, ebz};
      exp_q.push_back(e);
    end
    n_cyc++;
  endtask

  // Monitor: compare once per cycle, after inputs settle and before the edge.
  initial begin
    logic [7:0] e, got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {stall, bubble, flush, dstart, busy, tmo, dop};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: stall,bubble,flush,start,busy,tmo,op got %b required %b",
                   n_cyc, got, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; rs1 = 5'd0; rs2 = 5'd0; start = 1'b0; op = 2'd0;
    memrd = 1'b0; wr = 5'd0; br = 1'b0; done = 1'b0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on rs1, then gone; x0 destination never stalls
    cyc(1, 5, 0, 0, 0, 1, 5, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 5, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 3, 7, 0, 0, 1, 7, 0, 0);
    // normal DSP op, done in the 5th WAIT cycle, start held through release
    cyc(1, 1, 2, 1, DSP_OP_DIV, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 2, 1, DSP_OP_DIV, 0, 0, 0, (i == 5));
    cyc(1, 1, 2, 1, DSP_OP_MAC, 0, 0, 0, 0);
    cyc(1, 1, 2, 0, DSP_OP_MAC, 0, 0, 0, 0);
    // timeout: launch + 8 WAIT cycles, release, flag stays
    cyc(1, 1, 2, 1, DSP_OP_SQRT, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 2, (i < 9), DSP_OP_SQRT, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // branch beats load-use and DSP request
    cyc(1, 5, 0, 1, DSP_OP_MAC, 1, 5, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // done in the launch cycle, then branch during release
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, DSP_OP_MAC, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, DSP_OP_MAC, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, DSP_OP_MAC, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // done coincident with the last allowed WAIT cycle: no flag
    cyc(1, 0, 0, 1, DSP_OP_DIV, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, DSP_OP_DIV, 0, 0, (i == 4), (i == 8));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of WAIT with active inputs
    cyc(1, 0, 0, 1, DSP_OP_SQRT, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, DSP_OP_SQRT, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, DSP_OP_SQRT, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_hazard_ctrl.md
Name: dsp_hazard_ctrl

Overview:
- Pipeline sequencing controller between the decode stage and the EX-side DSP unit.
- Detects load-use hazards and issues the one-cycle stall and bubble.
- Launches multi-cycle DSP operations decoded in ID and holds the front end until the DSP reports done or times out.
- Applies the branch-taken flush.
- Drives the PC/IF-ID stall, the ID-EX bubble and the IF-ID flush controls.

Parameters:
- DSP_TIMEOUT, 64: max cycles in WAIT before forced release.
- CNT_W, 7: wait-counter width; must satisfy 2^CNT_W > DSP_TIMEOUT.
- OP_W, 2: DSP opcode width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_rs1  in  5  rs1 of the instruction in ID.
- i_id_rs2  in  5  rs2 of the instruction in ID.
- i_id_start_dsp  in  1  the ID instruction is a DSP op.
- i_id_op_dsp  in  OP_W  DSP opcode from ID.
- i_ex_MemRead  in  1  the instruction in EX is a load.
- i_ex_WriteReg  in  5  destination register of the EX instruction.
- i_branch_taken  in  1  branch resolved taken in EX.
- i_dsp_done  in  1  DSP result valid (single-cycle pulse).
- o_stall  out  1  hold PC and IF/ID.
- o_bubble  out  1  zero ID/EX control signals.
- o_flush  out  1  clear IF/ID.
- o_dsp_start  out  1  one-cycle launch pulse to the DSP.
- o_dsp_op  out  OP_W  latched opcode, stable from launch until the next launch.
- o_dsp_busy  out  1  high in LAUNCH and WAIT.
- o_dsp_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, counter=0, o_dsp_op=0, o_dsp_timeout=0. All outputs read 0 while reset is asserted. Reset mid-operation aborts the DSP sequence; no pulse is reissued.
- load_use = i_ex_MemRead & (i_ex_WriteReg!=0) & ((i_ex_WriteReg==i_id_rs1) | (i_ex_WriteReg==i_id_rs2)). This is combinational.
- Output decode is combinational from state and inputs; the FSM and o_dsp_op are registered.
- IDLE, evaluated in priority order:
  - 1) i_branch_taken: o_flush=1, o_bubble=1. Any DSP request is dropped, because the ID instruction is squashed. Stay in IDLE.
  - 2) load_use: o_stall=1, o_bubble=1 for this cycle only. Stay in IDLE. A DSP request is re-evaluated next cycle.
  - 3) i_id_start_dsp: o_stall=1, o_bubble=1. Latch i_id_op_dsp into o_dsp_op. Go to LAUNCH.
  - else: all outputs 0.
- LAUNCH (1 cycle): o_dsp_start=1, o_stall=1, o_bubble=1, o_dsp_busy=1. Clear the counter.
  - i_dsp_done=1 in this cycle is accepted: go to RELEASE.
  - Otherwise go to WAIT.
- WAIT: o_stall=1, o_bubble=1, o_dsp_busy=1. The counter increments each cycle.
  - i_dsp_done=1: go to RELEASE.
  - Else if counter==DSP_TIMEOUT-1: set o_dsp_timeout and go to RELEASE.
  - Done and timeout in the same cycle: done wins; the flag is not set.
- RELEASE (1 cycle): all stall, bubble and busy outputs are 0, so the held DSP instruction advances to EX. i_id_start_dsp is ignored in this cycle to prevent a relaunch. Go to IDLE.
  - i_branch_taken here still forces o_flush=1 and o_bubble=1.
- i_branch_taken in LAUNCH or WAIT is ignored, because EX holds a bubble.
- i_dsp_done in IDLE or RELEASE is ignored.
- o_dsp_timeout clears only on reset.
- Latency:
  - Launch pulse appears 1 cycle after the request is seen in IDLE.
  - Front end stalls for 2+N cycles, where N is the number of WAIT cycles.
  - Release occurs the cycle after done.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - the state enum (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RELEASE=2'd3);
  - the DSP opcode constants, OP_W wide;
  - DSP_TIMEOUT_DEF=64.
- One combinational sub-module, load_use_detect, computes load_use from rs1, rs2, the EX destination and MemRead.
- The FSM, counter and flags stay in the top module.

Test Plan:
- Load-use: EX MemRead=1, WriteReg=5, ID rs1=5 -> o_stall=1 and o_bubble=1 for exactly 1 cycle. WriteReg=0 with rs1=0 -> no stall.
- DSP normal: start_dsp=1, op=2'b10 in IDLE -> next cycle o_dsp_start=1, o_dsp_op=2'b10. Done pulse after 5 WAIT cycles -> RELEASE with o_stall=0, then IDLE. Total stall is 7 cycles. No second start pulse.
- Timeout: DSP_TIMEOUT=8, done never asserted -> o_dsp_timeout=1 after the 8th WAIT cycle. Stall releases and the flag stays high.
- Branch priority: i_branch_taken=1 together with start_dsp=1 and load_use=1 in IDLE -> o_flush=1, o_bubble=1, no launch, state stays IDLE.
- Done in LAUNCH: done=1 in the launch cycle -> RELEASE on the next cycle with no WAIT cycles. Done and timeout coincident -> flag stays 0.
- Reset mid-WAIT: drop i_reset to 0 during WAIT -> outputs go to 0 immediately (async). After release, IDLE with counter=0 and o_dsp_timeout=0.
